// File: rtl/mem_port_arbiter.sv
// Instruction-fetch / data-memory arbiter for one fixed-latency single-port 16-bit memory.
// Optional build macro ARB_RR_EN: round-robin contention instead of dm priority with starvation guard.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q, state_d;
    logic       grant;
    logic       pick_dm;
    logic       win_dm;
    logic [3:0] lat_cnt;
    logic       cap;
    logic       finish;

`ifdef ARB_RR_EN
    logic       last_dm;
`else
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;
`endif

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    assign cap    = (state_q == WAIT) && (lat_cnt == 4'd1);
    assign finish = ((state_q == ISSUE) && mem_we) || cap;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        pick_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant   = 1'b1;
`ifdef ARB_RR_EN
                    pick_dm = dm_req && (!if_req || !last_dm);
`else
                    pick_dm = dm_req && (!if_req || (starve_cnt != SMAX));
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = mem_we ? DONE : WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_addr/mem_we/mem_wdata double as the latched request for the whole access
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            win_dm     <= 1'b0;
            lat_cnt    <= '0;
`ifdef ARB_RR_EN
            last_dm    <= 1'b0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            mem_en   <= grant;
            if_valid <= finish & ~win_dm;
            dm_valid <= finish & win_dm;

            if (grant) begin
                win_dm    <= pick_dm;
                mem_addr  <= pick_dm ? dm_addr : if_addr;
                mem_we    <= pick_dm & dm_we;
                mem_wdata <= pick_dm ? dm_wdata : '0;
            end

            if (state_q == ISSUE)     lat_cnt <= LAT;
            else if (state_q == WAIT) lat_cnt <= lat_cnt - 4'd1;

            if (cap) begin
                if (win_dm) dm_rdata <= mem_rdata;
                else        if_rdata <= mem_rdata;
            end

`ifdef ARB_RR_EN
            if (grant) last_dm <= pick_dm;
`else
            if (state_q == IDLE) begin
                if (if_req && dm_req && pick_dm)
                    starve_cnt <= (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
                else
                    starve_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=3) on a delay-line memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst, if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;

    logic        b_rst, b_if_req, b_dm_req, b_dm_we;
    logic [15:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_valid, b_if_stall, b_dm_valid, b_dm_stall, b_mem_en, b_mem_we;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid), .if_stall(b_if_stall),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid), .dm_stall(b_dm_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // memory returns addr ^ 16'hA5B5 exactly MEM_LAT cycles after a read strobe, 16'hDEAD otherwise
    logic [15:0] pa [2];
    logic [15:0] pb [3];
    always @(posedge clk) begin
        pa[0] <= (mem_en && !mem_we) ? (mem_addr ^ 16'hA5B5) : 16'hDEAD;
        pa[1] <= pa[0];
        pb[0] <= (b_mem_en && !b_mem_we) ? (b_mem_addr ^ 16'hA5B5) : 16'hDEAD;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign mem_rdata   = pa[1];
    assign b_mem_rdata = pb[2];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    logic exp_dm [6];
    int   waited;
    int   dm_pulses;

    initial begin
`ifdef ARB_RR_EN
        exp_dm = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        b_rst = 1'b1; b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_we = 1'b0;
        b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0;
        repeat (3) tick();
        rst = 1'b0; b_rst = 1'b0;
        #1;

        chk("rst_if_valid", 16'(if_valid), 16'h0);
        chk("rst_dm_valid", 16'(dm_valid), 16'h0);
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_if_rdata", if_rdata, 16'h0);
        chk("rst_b_mem_en", 16'(b_mem_en), 16'h0);

        // single fetch read, MEM_LAT=2
        if_req = 1'b1; if_addr = 16'h0010;
        #1 chk("f_stall_T", 16'(if_stall), 16'h1);
        tick();
        chk("f_mem_en_T1", 16'(mem_en), 16'h1);
        chk("f_mem_addr_T1", mem_addr, 16'h0010);
        chk("f_mem_we_T1", 16'(mem_we), 16'h0);
        chk("f_stall_T1", 16'(if_stall), 16'h1);
        tick();
        chk("f_mem_en_T2", 16'(mem_en), 16'h0);
        chk("f_stall_T2", 16'(if_stall), 16'h1);
        tick();
        chk("f_valid_T3", 16'(if_valid), 16'h0);
        chk("f_stall_T3", 16'(if_stall), 16'h1);
        tick();
        chk("f_valid_T4", 16'(if_valid), 16'h1);
        chk("f_rdata_T4", if_rdata, 16'hA5A5);
        chk("f_stall_T4", 16'(if_stall), 16'h0);
        if_req = 1'b0;
        tick();
        chk("f_valid_T5", 16'(if_valid), 16'h0);

        // data write
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h8000; dm_wdata = 16'h1234;
        #1 chk("w_stall_T", 16'(dm_stall), 16'h1);
        tick();
        chk("w_mem_en_T1", 16'(mem_en), 16'h1);
        chk("w_mem_we_T1", 16'(mem_we), 16'h1);
        chk("w_mem_addr_T1", mem_addr, 16'h8000);
        chk("w_mem_wdata_T1", mem_wdata, 16'h1234);
        chk("w_valid_T1", 16'(dm_valid), 16'h0);
        tick();
        chk("w_valid_T2", 16'(dm_valid), 16'h1);
        chk("w_stall_T2", 16'(dm_stall), 16'h0);
        chk("w_mem_en_T2", 16'(mem_en), 16'h0);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        chk("w_valid_T3", 16'(dm_valid), 16'h0);

        // contention with both requests held, starting from reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_addr = 16'h0030; dm_we = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            while (!if_valid && !dm_valid && waited < 20) begin
                chk($sformatf("c%0d_if_stall_wait", k), 16'(if_stall), 16'h1);
                tick();
                waited++;
            end
            if (waited >= 20) begin
                chk($sformatf("c%0d_timeout", k), 16'h0, 16'h1);
                break;
            end
            chk($sformatf("c%0d_spacing", k), 16'(waited), 16'd4);
            chk($sformatf("c%0d_grant_dm", k), 16'(dm_valid), 16'(exp_dm[k]));
            chk($sformatf("c%0d_one_valid", k), 16'(if_valid & dm_valid), 16'h0);
            chk($sformatf("c%0d_if_stall", k), 16'(if_stall), 16'(!if_valid));
            if (dm_valid) chk($sformatf("c%0d_dm_rdata", k), dm_rdata, 16'hA585);
            else          chk($sformatf("c%0d_if_rdata", k), if_rdata, 16'hA595);
            if (k == 5) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            tick();
        end

        // reset during WAIT abandons the read
        if_req = 1'b1; if_addr = 16'h0040;
        tick();
        chk("r_mem_en_T1", 16'(mem_en), 16'h1);
        tick();
        rst = 1'b1; if_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("r_mem_en_T3", 16'(mem_en), 16'h0);
        chk("r_if_valid_T3", 16'(if_valid), 16'h0);
        chk("r_if_rdata_T3", if_rdata, 16'h0);
        chk("r_dm_rdata_T3", dm_rdata, 16'h0);
        if_req = 1'b1; if_addr = 16'h0050;
        tick();
        chk("r_mem_en_T4", 16'(mem_en), 16'h1);
        chk("r_mem_addr_T4", mem_addr, 16'h0050);
        chk("r_if_valid_T4", 16'(if_valid), 16'h0);
        tick();
        chk("r_if_valid_T5", 16'(if_valid | dm_valid), 16'h0);
        tick();
        chk("r_if_valid_T6", 16'(if_valid | dm_valid), 16'h0);
        tick();
        chk("r_if_valid_T7", 16'(if_valid), 16'h1);
        chk("r_if_rdata_T7", if_rdata, 16'hA5E5);
        if_req = 1'b0;
        tick();

        // dm drops its request during WAIT, MEM_LAT=3, fetch pending
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 16'h0050;
        b_if_req = 1'b1; b_if_addr = 16'h0060;
        tick();
        chk("d_mem_en_T1", 16'(b_mem_en), 16'h1);
        chk("d_mem_addr_T1", b_mem_addr, 16'h0050);
        tick();
        b_dm_req = 1'b0;
        #1;
        chk("d_dm_stall_drop", 16'(b_dm_stall), 16'h0);
        chk("d_if_stall_drop", 16'(b_if_stall), 16'h1);
        dm_pulses = 0;
        for (int c = 3; c <= 11; c++) begin
            tick();
            if (b_dm_valid) dm_pulses++;
            if (c == 5) begin
                chk("d_dm_valid_T5", 16'(b_dm_valid), 16'h1);
                chk("d_dm_rdata_T5", b_dm_rdata, 16'hA5E5);
                chk("d_dm_stall_T5", 16'(b_dm_stall), 16'h0);
            end
            if (c == 7) begin
                chk("d_mem_en_T7", 16'(b_mem_en), 16'h1);
                chk("d_mem_addr_T7", b_mem_addr, 16'h0060);
                chk("d_mem_we_T7", 16'(b_mem_we), 16'h0);
            end
            if (c >= 8 && c <= 10) chk($sformatf("d_if_valid_T%0d", c), 16'(b_if_valid), 16'h0);
            if (c == 11) begin
                chk("d_if_valid_T11", 16'(b_if_valid), 16'h1);
                chk("d_if_rdata_T11", b_if_rdata, 16'hA5D5);
                b_if_req = 1'b0;
            end
        end
        chk("d_dm_pulse_count", 16'(dm_pulses), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 16-bit unified memory between the instruction-fetch stage and the data-memory stage.
- Sequences each access through a fixed-latency memory:
  - latches the winning request,
  - issues one memory cycle,
  - waits the memory latency,
  - returns read data with a one-cycle valid pulse.
- Drives per-requester stall lines. if_stall feeds the fetch stage hold input; dm_stall feeds the pipeline hazard logic.

Parameters:
- MEM_LAT, 2: cycles from the mem_en cycle to mem_rdata valid (1..15).
- STARVE_MAX, 4: consecutive lost arbitrations after which fetch wins (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  16  fetch address
- if_rdata  out  16  fetched instruction
- if_valid  out  1  one-cycle pulse, if_rdata valid
- if_stall  out  1  fetch must hold
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  16  data address
- dm_wdata  in  16  write data
- dm_rdata  out  16  read data
- dm_valid  out  1  one-cycle pulse, read data valid or write done
- dm_stall  out  1  data stage must hold
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset: rst sampled high at a rising edge sets all of the following to 0:
  - outputs: if_rdata, dm_rdata, if_valid, dm_valid, mem_en, mem_we, mem_addr, mem_wdata;
  - internals: latency counter, starvation counter, last-grant flag;
  - FSM returns to IDLE.
- Reset mid-transfer abandons the access; no valid pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is present, arbitrate and latch the winner id, addr, we and wdata.
  - A fetch grant always has we = 0.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - mem_en = 1 for exactly this cycle; mem_we, mem_addr, mem_wdata come from the latched values.
  - Write: go to DONE.
  - Read: load counter = MEM_LAT, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, capture mem_rdata into the winner's rdata register and go to DONE.
- DONE:
  - Winner's valid = 1 for this cycle only; go to IDLE.
- Latency:
  - Read granted in IDLE cycle T: valid at T+2+MEM_LAT.
  - Write granted at T: valid at T+2.
  - Back-to-back throughput: one access per 3+MEM_LAT cycles for reads, 3 cycles for writes.
- Stall rule:
  - x_stall = x_req AND NOT x_valid, combinational.
  - The requester advances on the edge ending its valid cycle and may present a new request in the following cycle. That cycle is IDLE, so there is no bubble beyond the FSM itself.
- Requests dropped after grant: the access still completes and valid still pulses. Stall deasserts immediately.
- Request inputs changing while not granted: only the values present at the IDLE grant cycle matter.
- rdata registers hold their last captured value until the next capture.
- Arbitration (default), evaluated only in IDLE:
  - Only one requester present: it wins.
  - Both present: dm wins (older instruction) unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments by 1 when both request and dm wins.
  - starve_cnt clears to 0 when fetch wins, and when fetch is not requesting in IDLE.
  - starve_cnt saturates at STARVE_MAX.
- Stall with no grant: the losing requester keeps stall high through the entire other transaction.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: when both request in IDLE, the grant alternates using a last-grant flag, and the starvation counter is not built.
  - The flag updates on every grant and resets to "last = fetch", so dm wins the first contention.
  - A single requester always wins.
- Undefined: dm priority with STARVE_MAX starvation guard, as described above.

Test Plan:
- Reset then single fetch, MEM_LAT=2: if_req=1, if_addr=0x0010, memory returns 0xA5A5 → mem_en at T+1 with mem_addr=0x0010, mem_we=0; if_valid at T+4 with if_rdata=0xA5A5; if_stall high T..T+3, low at T+4.
- Data write: dm_req=1, dm_we=1, dm_addr=0x8000, dm_wdata=0x1234 → mem_en=1, mem_we=1, mem_wdata=0x1234 at T+1; dm_valid at T+2; no WAIT cycles.
- Contention, both held continuously, STARVE_MAX=4, default build → grant order dm, dm, dm, dm, fetch, dm…; fetch gets its first grant on the 5th arbitration; if_stall stays high until that grant's if_valid.
- ARB_RR_EN build, both held → grant order dm, fetch, dm, fetch; each requester sees valid exactly once per pair of transactions.
- Reset mid-read: rst=1 in the WAIT cycle → next cycle FSM is IDLE and mem_en=0; no if_valid or dm_valid pulse; if_rdata=0.
- Requester drops dm_req in WAIT, MEM_LAT=3 → dm_stall low immediately; dm_valid still pulses once with captured data; the next IDLE grants a pending fetch.
